// File: rtl/muller_c_array.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_array
// Brief    : Array of clocked generalised Muller C-elements with input
//            synchroniser, per-input enable mask, stability filter, saturating
//            transition counters and a registered all-high completion flag.
// Revision : 1.0 - initial release
// ============================================================================
module muller_c_array #(
    parameter int CHANNELS    = 2,
    parameter int N_IN        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2,
    parameter int CNT_W       = 4,
    parameter int RESET_VAL   = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*N_IN-1:0]  io_in,
    input  logic [N_IN-1:0]           en_mask,
    input  logic                      cnt_clear,
    output logic [CHANNELS-1:0]       c_out,
    output logic [CHANNELS*CNT_W-1:0] toggle_cnt,
    output logic                      all_done
);

    localparam int         c_W         = CHANNELS * N_IN;
    localparam logic [3:0] c_FILTER    = 4'(FILTER);
    localparam logic       c_RESET_BIT = 1'(RESET_VAL);

    logic [c_W-1:0]      w_s_in;
    logic [CHANNELS-1:0] w_c_out;
    logic                r_all_done;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s_in = io_in;
        end else begin : g_sync
            logic [c_W-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= io_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s_in = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            logic [N_IN-1:0]  w_x;
            logic             w_mask_any;
            logic             w_rise;
            logic             w_fall;
            logic             w_target;
            logic             w_flip;
            logic             r_c;
            logic [3:0]       r_stab;
            logic [CNT_W-1:0] r_cnt;

            assign w_x        = w_s_in[k*N_IN +: N_IN];
            assign w_mask_any = |en_mask;
            assign w_rise     = w_mask_any && ((w_x & en_mask) == en_mask);
            assign w_fall     = w_mask_any && ((w_x & en_mask) == '0);
            // An all-zero mask satisfies neither condition, so the channel holds.
            assign w_target   = w_rise ? 1'b1 : (w_fall ? 1'b0 : r_c);
            assign w_flip     = (w_target != r_c) && (r_stab == c_FILTER);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_c    <= c_RESET_BIT;
                    r_stab <= '0;
                end else if (w_target == r_c) begin
                    r_stab <= '0;
                end else if (r_stab == c_FILTER) begin
                    r_c    <= w_target;
                    r_stab <= '0;
                end else begin
                    r_stab <= r_stab + 4'd1;
                end
            end

            // Clear wins over a coincident transition; count sticks at all-ones.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (cnt_clear) begin
                    r_cnt <= '0;
                end else if (w_flip && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            assign w_c_out[k]                  = r_c;
            assign toggle_cnt[k*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_all_done <= c_RESET_BIT;
        end else begin
            r_all_done <= &w_c_out;
        end
    end

    assign c_out    = w_c_out;
    assign all_done = r_all_done;

endmodule
`default_nettype wire

// File: tb/tb_muller_c_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_muller_c_array
// Brief    : Directed, table-driven self-checking bench for muller_c_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muller_c_array;

    logic       clock;
    logic       reset_n;
    logic [5:0] io_in;
    logic [2:0] en_mask;
    logic       cnt_clear;
    logic [1:0] c_out;
    logic [7:0] toggle_cnt;
    logic       all_done;

    int n_cmp;
    int n_bad;

    muller_c_array #(
        .CHANNELS(2), .N_IN(3), .SYNC_STAGES(2), .FILTER(2), .CNT_W(4), .RESET_VAL(0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .io_in(io_in),
        .en_mask(en_mask),
        .cnt_clear(cnt_clear),
        .c_out(c_out),
        .toggle_cnt(toggle_cnt),
        .all_done(all_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] io;
        logic [2:0] mask;
        logic       clr;
        int         edges;
        logic [1:0] exp_c;
        logic [7:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] ec,
                           input logic [7:0] ecnt, input logic ed);
        chk({name, ".c_out"}, 32'(c_out), 32'(ec));
        chk({name, ".toggle_cnt"}, 32'(toggle_cnt), 32'(ecnt));
        chk({name, ".all_done"}, 32'(all_done), 32'(ed));
    endtask

    initial begin
        int   cnt0;
        logic c0;
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        io_in     = '0;
        en_mask   = 3'b111;
        cnt_clear = 1'b0;

        vecs[0]  = '{6'b010110, 3'b111, 1'b0,  6, 2'b00, 8'h00, 1'b0};
        vecs[1]  = '{6'b111000, 3'b111, 1'b0,  4, 2'b00, 8'h00, 1'b0};
        vecs[2]  = '{6'b111000, 3'b111, 1'b0,  1, 2'b10, 8'h10, 1'b0};
        vecs[3]  = '{6'b000000, 3'b111, 1'b0,  4, 2'b10, 8'h10, 1'b0};
        vecs[4]  = '{6'b000000, 3'b111, 1'b0,  1, 2'b00, 8'h20, 1'b0};
        vecs[5]  = '{6'b000011, 3'b011, 1'b0,  5, 2'b01, 8'h21, 1'b0};
        vecs[6]  = '{6'b000000, 3'b000, 1'b0, 10, 2'b01, 8'h21, 1'b0};
        vecs[7]  = '{6'b111111, 3'b111, 1'b0,  5, 2'b11, 8'h31, 1'b0};
        vecs[8]  = '{6'b111111, 3'b111, 1'b0,  1, 2'b11, 8'h31, 1'b1};
        vecs[9]  = '{6'b000111, 3'b111, 1'b0,  5, 2'b01, 8'h41, 1'b1};
        vecs[10] = '{6'b000111, 3'b111, 1'b0,  1, 2'b01, 8'h41, 1'b0};
        vecs[11] = '{6'b000000, 3'b111, 1'b0,  5, 2'b00, 8'h42, 1'b0};

        tick(2);
        chk_all("reset_state", 2'b00, 8'h00, 1'b0);
        reset_n = 1'b1;
        tick(1);
        chk_all("post_release", 2'b00, 8'h00, 1'b0);

        for (int i = 0; i < 12; i++) begin
            io_in     = vecs[i].io;
            en_mask   = vecs[i].mask;
            cnt_clear = vecs[i].clr;
            tick(vecs[i].edges);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_cnt, vecs[i].exp_done);
        end

        // Short pulse on channel 0 must be filtered out.
        io_in = 6'b000111;
        tick(2);
        io_in = 6'b000011;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk($sformatf("glitch_c%0d", i), 32'(c_out), 32'h0);
        end
        chk("glitch_cnt", 32'(toggle_cnt), 32'h42);
        io_in = 6'b000111;
        tick(4);
        chk("hold_before", 32'(c_out), 32'h0);
        tick(1);
        chk("hold_rise_c", 32'(c_out), 32'h1);
        chk("hold_rise_cnt", 32'(toggle_cnt), 32'h43);

        // Twenty toggles on channel 0: counter saturates at 15.
        cnt0 = 3;
        for (int i = 0; i < 20; i++) begin
            io_in = (i % 2 == 0) ? 6'b000000 : 6'b000111;
            c0    = (i % 2 == 0) ? 1'b0 : 1'b1;
            cnt0  = (cnt0 < 15) ? cnt0 + 1 : 15;
            tick(5);
            chk($sformatf("sat_c%0d", i), 32'(c_out), 32'(c0));
            chk($sformatf("sat_cnt%0d", i), 32'(toggle_cnt), 32'({4'h4, 4'(cnt0)}));
        end

        // Clear coincident with a channel-0 fall.
        io_in = 6'b000000;
        tick(4);
        chk("clr_pre_c", 32'(c_out), 32'h1);
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        chk("clr_edge_c", 32'(c_out), 32'h0);
        chk("clr_edge_cnt", 32'(toggle_cnt), 32'h00);
        tick(1);
        chk("clr_after_cnt", 32'(toggle_cnt), 32'h00);

        // Asynchronous reset mid-cycle with both channels high.
        io_in = 6'b111111;
        tick(5);
        chk_all("both_high", 2'b11, 8'h11, 1'b0);
        tick(1);
        chk_all("both_done", 2'b11, 8'h11, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_reset", 2'b00, 8'h00, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        io_in   = 6'b010110;
        tick(6);
        chk_all("after_reset", 2'b00, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
